// File: rtl/qbus_dl11.sv
// qbus_dl11: DL11-compatible console serial port as a QBUS slave.
// Decodes RCSR/RBUF/XCSR/XBUF in the I/O page and answers DIN, DOUT and IAKO cycles.
// Raises a vectored interrupt and runs an 8N1 UART on tx/rx.
module qbus_dl11 #(
    parameter logic [12:0] REG_BASE = 13'o17560,
    parameter logic [15:0] VEC_BASE = 16'o000060,
    parameter int          BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_n,
    input  logic [15:0] ad_n,
    output logic [15:0] ad_out_n,
    output logic        ad_oe,
    input  logic        sync_n,
    input  logic        bs_n,
    input  logic        din_n,
    input  logic        dout_n,
    input  logic        wtbt_n,
    input  logic        iako_n,
    output logic        rply_n,
    output logic        virq_n,
    input  logic        rx,
    output logic        tx
);

    localparam int            CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        BUS_IDLE,
        BUS_RD,
        BUS_RD_RPLY,
        BUS_WR,
        BUS_WR_RPLY
    } bus_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // QBUS INIT acts exactly like the system reset
    logic srst;
    assign srst = rst | ~init_n;

    logic [15:0] ad_inv;
    assign ad_inv = ~ad_n;

    // Upper address bits are don't-care: bs_n already selects the I/O page
    logic unused_ad;
    assign unused_ad = &{1'b0, ad_inv[15:13]};

    // ------------------------------------------------------------------
    // Synchronizers for the bus strobes and rx: {sync, din, dout, iako, rx}
    // ------------------------------------------------------------------
    logic [4:0] meta, synced, prev;
    logic       s_din_n, s_dout_n, s_iako_n, s_rx;
    logic       sync_fall, sync_rise, rx_fall;

    // Two flops per strobe, plus a third copy used for edge detection
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (srst) begin
            meta   <= '1;
            synced <= '1;
            prev   <= '1;
        end else begin
            meta   <= {sync_n, din_n, dout_n, iako_n, rx};
            synced <= meta;
            prev   <= synced;
        end
    end

    assign s_din_n   = synced[3];
    assign s_dout_n  = synced[2];
    assign s_iako_n  = synced[1];
    assign s_rx      = synced[0];
    assign sync_fall = prev[4] & ~synced[4];
    assign sync_rise = ~prev[4] & synced[4];
    assign rx_fall   = prev[0] & ~synced[0];

    // ------------------------------------------------------------------
    // Address phase
    // ------------------------------------------------------------------
    logic       sel;
    logic [1:0] reg_idx;
    logic       addr_odd;

    // Latch the word address at SYNC and hold the select until SYNC is released
    always_ff @(posedge clk) begin
        if (srst) begin
            sel      <= 1'b0;
            reg_idx  <= 2'd0;
            addr_odd <= 1'b0;
        end else if (sync_fall) begin
            sel      <= ~bs_n && (ad_inv[12:3] == REG_BASE[12:3]);
            reg_idx  <= ad_inv[2:1];
            addr_odd <= ad_inv[0];
        end else if (sync_rise) begin
            sel <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Bus cycle FSM
    // ------------------------------------------------------------------
    bus_state_t bus_state, bus_next;
    logic       rd_go, iak_go, wr_go;
    logic       rx_req, tx_req;

    // Bus state register
    always_ff @(posedge clk) begin
        if (srst) bus_state <= BUS_IDLE;
        else      bus_state <= bus_next;
    end

    // Next state and one-cycle action strobes for read, vector and write
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        bus_next = bus_state;
        rd_go    = 1'b0;
        iak_go   = 1'b0;
        wr_go    = 1'b0;
        case (bus_state)
            BUS_IDLE: begin
                if (!s_iako_n && !s_din_n) begin
                    if (rx_req || tx_req) begin
                        iak_go   = 1'b1;
                        bus_next = BUS_RD;
                    end
                end else if (sel && !s_din_n) begin
                    rd_go    = 1'b1;
                    bus_next = BUS_RD;
                end else if (sel && !s_dout_n) begin
                    bus_next = BUS_WR;
                end
            end
            BUS_RD:      bus_next = BUS_RD_RPLY;
            BUS_RD_RPLY: if (s_din_n) bus_next = BUS_IDLE;
            BUS_WR: begin
                wr_go    = 1'b1;
                bus_next = BUS_WR_RPLY;
            end
            BUS_WR_RPLY: if (s_dout_n) bus_next = BUS_IDLE;
            default:     bus_next = BUS_IDLE;
        endcase
    end

    logic [15:0] ad_drive_n;
    assign ad_oe    = (bus_state == BUS_RD) || (bus_state == BUS_RD_RPLY);
    assign rply_n   = ~((bus_state == BUS_RD_RPLY) || (bus_state == BUS_WR_RPLY));
    assign ad_out_n = ad_oe ? ad_drive_n : 16'hFFFF;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic       rx_ie, tx_ie, rx_done, tx_ready;
    logic       rx_or, rx_fe;
    logic [7:0] rx_data;
    logic [15:0] rd_data;

    // Read mux for the addressed register
    always_comb begin
        rd_data = '0;
        case (reg_idx)
            2'd0: begin
                rd_data[7] = rx_done;
                rd_data[6] = rx_ie;
            end
            2'd1: rd_data = {rx_or | rx_fe, rx_or, rx_fe, 5'd0, rx_data};
            2'd2: begin
                rd_data[7] = tx_ready;
                rd_data[6] = tx_ie;
            end
            default: rd_data = '0;
        endcase
    end

    // Capture read data or interrupt vector when the cycle starts
    always_ff @(posedge clk) begin
        if (srst)        ad_drive_n <= '1;
        else if (iak_go) ad_drive_n <= rx_req ? ~VEC_BASE : ~(VEC_BASE + 16'd4);
        else if (rd_go)  ad_drive_n <= ~rd_data;
    end

    // A byte write to the odd byte touches no implemented bit and is dropped
    logic wr_accept, rcsr_wr, xcsr_wr, xbuf_wr, rbuf_rd;
    assign wr_accept = wr_go && !(!wtbt_n && addr_odd);
    assign rcsr_wr   = wr_accept && (reg_idx == 2'd0);
    assign xcsr_wr   = wr_accept && (reg_idx == 2'd2);
    assign xbuf_wr   = wr_accept && (reg_idx == 2'd3);
    assign rbuf_rd   = rd_go && (reg_idx == 2'd1);

    // Interrupt enable bits
    always_ff @(posedge clk) begin
        if (srst) begin
            rx_ie <= 1'b0;
            tx_ie <= 1'b0;
        end else begin
            if (rcsr_wr) rx_ie <= ad_inv[6];
            if (xcsr_wr) tx_ie <= ad_inv[6];
        end
    end

    // ------------------------------------------------------------------
    // Transmitter: start bit goes out at the load edge, READY returns 10 bits later
    // ------------------------------------------------------------------
    logic          tx_busy, tx_line;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_sh;

    // Bit timing and shifting of the transmit frame
    always_ff @(posedge clk) begin
        if (srst) begin
            tx_busy  <= 1'b0;
            tx_ready <= 1'b1;
            tx_line  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= 4'd0;
            tx_sh    <= '1;
        end else if (xbuf_wr && tx_ready) begin
            tx_busy  <= 1'b1;
            tx_ready <= 1'b0;
            tx_line  <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= 4'd0;
            tx_sh    <= {1'b1, ad_inv[7:0]};
        end else if (tx_busy) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_busy  <= 1'b0;
                    tx_ready <= 1'b1;
                    tx_line  <= 1'b1;
                end else begin
                    tx_line <= tx_sh[0];
                    tx_sh   <= {1'b1, tx_sh[8:1]};
                    tx_bit  <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    assign tx = tx_line;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          char_done;

    // Receiver state register
    always_ff @(posedge clk) begin
        if (srst) rx_state <= RX_IDLE;
        else      rx_state <= rx_next;
    end

    // Receiver sequencing: start check at half bit, then one sample per bit
    always_comb begin
        rx_next   = rx_state;
        char_done = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_cnt == HALF_LAST) rx_next = s_rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    char_done = 1'b1;
                    rx_next   = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // Receive datapath, status flags and the DONE set/clear arbitration
    always_ff @(posedge clk) begin
        if (srst) begin
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_done  <= 1'b0;
            rx_or    <= 1'b0;
            rx_fe    <= 1'b0;
        end else begin
            if (rx_state == RX_IDLE || rx_next != rx_state || rx_cnt == BIT_LAST)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;

            if (rx_state == RX_START)
                rx_bit <= 3'd0;
            else if (rx_state == RX_DATA && rx_cnt == BIT_LAST) begin
                rx_shift <= {s_rx, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end

            // A character completing in the same clock as an RBUF read keeps DONE set
            if (char_done) begin
                rx_data <= rx_shift;
                rx_fe   <= ~s_rx;
                rx_or   <= rx_done;
                rx_done <= 1'b1;
            end else if (rbuf_rd) begin
                rx_done <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Interrupt requests
    // ------------------------------------------------------------------
    logic rx_int, tx_int, rx_int_q, tx_int_q;
    assign rx_int = rx_done & rx_ie;
    assign tx_int = tx_ready & tx_ie;

    // Requests set on a rising DONE&IE / READY&IE, cleared by IE=0, RBUF read or ack
    always_ff @(posedge clk) begin
        if (srst) begin
            rx_int_q <= 1'b0;
            tx_int_q <= 1'b0;
            rx_req   <= 1'b0;
            tx_req   <= 1'b0;
        end else begin
            rx_int_q <= rx_int;
            tx_int_q <= tx_int;

            if (!rx_ie || rbuf_rd || (iak_go && rx_req)) rx_req <= 1'b0;
            else if (rx_int && !rx_int_q)                rx_req <= 1'b1;

            if (!tx_ie || (iak_go && !rx_req))           tx_req <= 1'b0;
            else if (tx_int && !tx_int_q)                tx_req <= 1'b1;
        end
    end

    assign virq_n = ~(rx_req | tx_req);

endmodule

// File: tb/tb_qbus_dl11.sv
// tb_qbus_dl11: table-driven register tests plus hand-written serial and interrupt sequences.
module tb_qbus_dl11;

    localparam int          BAUD = 16;
    localparam logic [15:0] RCSR = 16'o177560;
    localparam logic [15:0] RBUF = 16'o177562;
    localparam logic [15:0] XCSR = 16'o177564;
    localparam logic [15:0] XBUF = 16'o177566;

    logic        clk = 1'b0;
    logic        rst, init_n;
    logic [15:0] ad_n, ad_out_n;
    logic        ad_oe, sync_n, bs_n, din_n, dout_n, wtbt_n, iako_n;
    logic        rply_n, virq_n, rx, tx;

    always #5 clk = ~clk;

    qbus_dl11 #(
        .REG_BASE(13'o17560),
        .VEC_BASE(16'o000060),
        .BAUD_DIV(BAUD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .init_n  (init_n),
        .ad_n    (ad_n),
        .ad_out_n(ad_out_n),
        .ad_oe   (ad_oe),
        .sync_n  (sync_n),
        .bs_n    (bs_n),
        .din_n   (din_n),
        .dout_n  (dout_n),
        .wtbt_n  (wtbt_n),
        .iako_n  (iako_n),
        .rply_n  (rply_n),
        .virq_n  (virq_n),
        .rx      (rx),
        .tx      (tx)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic        tx_exp_q[$];

    typedef struct {
        logic        wr;
        logic        bw;
        logic [15:0] addr;
        logic [15:0] data;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %06o want %06o", name, act, exp);
        end
    endtask

    task automatic wait_rply(input logic lvl, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rply_n == lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic bus_addr(input logic [15:0] a, input logic io);
        @(negedge clk);
        ad_n   = ~a;
        bs_n   = ~io;
        sync_n = 1'b0;
        repeat (4) @(negedge clk);
        ad_n = '1;
        bs_n = 1'b1;
    endtask

    task automatic bus_end();
        @(negedge clk);
        sync_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic bus_read(input string name, input logic [15:0] a, input logic [15:0] exp);
        logic        ok;
        logic [15:0] want;
        bus_addr(a, 1'b1);
        exp_q.push_back(exp);
        din_n = 1'b0;
        wait_rply(1'b0, ok);
        check({name, " rply"}, 16'(ok), 16'd1);
        want = exp_q.pop_front();
        if (ok) begin
            check(name, ~ad_out_n, want);
            check({name, " oe"}, 16'(ad_oe), 16'd1);
        end
        din_n = 1'b1;
        wait_rply(1'b1, ok);
        check({name, " release"}, 16'({ok, ad_oe}), 16'b10);
        bus_end();
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic bw);
        logic ok;
        bus_addr(a, 1'b1);
        ad_n   = ~d;
        wtbt_n = ~bw;
        dout_n = 1'b0;
        wait_rply(1'b0, ok);
        check($sformatf("wr %06o rply", a), 16'(ok), 16'd1);
        dout_n = 1'b1;
        wait_rply(1'b1, ok);
        ad_n   = '1;
        wtbt_n = 1'b1;
        bus_end();
    endtask

    task automatic bus_noresp(input string name, input logic [15:0] a, input logic io);
        logic seen;
        seen = 1'b0;
        bus_addr(a, io);
        din_n = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | ~rply_n | ad_oe;
        end
        check(name, 16'(seen), 16'd0);
        din_n = 1'b1;
        bus_end();
    endtask

    task automatic iak(input string name, input logic [15:0] exp);
        logic        ok;
        logic [15:0] want;
        @(negedge clk);
        exp_q.push_back(exp);
        iako_n = 1'b0;
        din_n  = 1'b0;
        wait_rply(1'b0, ok);
        check({name, " rply"}, 16'(ok), 16'd1);
        want = exp_q.pop_front();
        if (ok) check(name, ~ad_out_n, want);
        iako_n = 1'b1;
        din_n  = 1'b1;
        wait_rply(1'b1, ok);
        check({name, " release"}, 16'(ok), 16'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = stop;
        repeat (BAUD) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Watches one transmitted frame, samples each bit mid-cell, then times READY
    task automatic tx_monitor(input logic [7:0] d);
        logic ok;
        logic want;
        tx_exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_exp_q.push_back(d[i]);
        tx_exp_q.push_back(1'b1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("tx start seen", 16'(ok), 16'd1);
        if (ok) begin
            repeat (BAUD / 2) @(negedge clk);
            for (int k = 0; k < 10; k++) begin
                if (k > 0) repeat (BAUD) @(negedge clk);
                want = tx_exp_q.pop_front();
                check($sformatf("tx bit %0d", k), 16'(tx), 16'(want));
            end
            repeat (BAUD / 2 - 1) @(negedge clk);
            check("ready before 10 bits", 16'(dut.tx_ready), 16'd0);
            @(negedge clk);
            check("ready at 10 bits", 16'(dut.tx_ready), 16'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b0, XCSR,         16'o000200};
        vecs[1]  = '{1'b0, 1'b0, RCSR,         16'o000000};
        vecs[2]  = '{1'b1, 1'b0, RCSR,         16'o000100};
        vecs[3]  = '{1'b0, 1'b0, RCSR,         16'o000100};
        vecs[4]  = '{1'b1, 1'b0, RCSR,         16'o177777};
        vecs[5]  = '{1'b0, 1'b0, RCSR,         16'o000100};
        vecs[6]  = '{1'b1, 1'b0, RCSR,         16'o000000};
        vecs[7]  = '{1'b1, 1'b1, XCSR + 16'd1, 16'o040100};
        vecs[8]  = '{1'b0, 1'b0, XCSR,         16'o000200};
        vecs[9]  = '{1'b1, 1'b1, XCSR,         16'o000100};
        vecs[10] = '{1'b0, 1'b0, XCSR,         16'o000300};
        vecs[11] = '{1'b1, 1'b0, XCSR,         16'o000000};
        vecs[12] = '{1'b0, 1'b0, XCSR,         16'o000200};

        rst    = 1'b1;
        init_n = 1'b1;
        ad_n   = '1;
        sync_n = 1'b1;
        bs_n   = 1'b1;
        din_n  = 1'b1;
        dout_n = 1'b1;
        wtbt_n = 1'b1;
        iako_n = 1'b1;
        rx     = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset rply_n",   16'(rply_n), 16'd1);
        check("reset ad_oe",    16'(ad_oe),  16'd0);
        check("reset ad_out_n", ad_out_n,    16'hFFFF);
        check("reset virq_n",   16'(virq_n), 16'd1);
        check("reset tx",       16'(tx),     16'd1);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data, vecs[i].bw);
            else            bus_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data);
        end

        // Transmit 0101 and watch the frame while XCSR is read mid-frame
        fork
            begin
                bus_write(XBUF, 16'o000101, 1'b0);
                bus_read("XCSR busy", XCSR, 16'o000000);
            end
            tx_monitor(8'o101);
        join
        bus_read("XCSR ready", XCSR, 16'o000200);

        // Receive 0x55, read it, DONE clears
        send_rx(8'h55, 1'b1);
        bus_read("RCSR done", RCSR, 16'o000200);
        bus_read("RBUF 0x55", RBUF, 16'o000125);
        bus_read("RCSR cleared", RCSR, 16'o000000);

        // Short low pulse on rx must not produce a character
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (12 * BAUD) @(negedge clk);
        bus_read("RCSR after glitch", RCSR, 16'o000000);

        // Both interrupts pending: receiver vector first, then transmitter
        bus_write(XCSR, 16'o000100, 1'b0);
        bus_write(RCSR, 16'o000100, 1'b0);
        send_rx(8'h5A, 1'b1);
        @(negedge clk);
        check("virq pending", 16'(virq_n), 16'd0);
        iak("IAK rx vector", 16'o000060);
        iak("IAK tx vector", 16'o000064);
        check("virq after acks", 16'(virq_n), 16'd1);

        // Overrun, then framing error, then a clean character clears errors
        send_rx(8'h33, 1'b1);
        bus_read("RBUF overrun", RBUF, 16'o140063);
        bus_write(RCSR, 16'o000000, 1'b0);
        bus_write(XCSR, 16'o000000, 1'b0);
        send_rx(8'hA5, 1'b0);
        bus_read("RBUF framing", RBUF, 16'o120245);
        send_rx(8'h0F, 1'b1);
        bus_read("RBUF clean", RBUF, 16'o000017);

        // Cycles that must not be answered
        bus_noresp("no rply bs_n high", RCSR, 1'b0);
        bus_noresp("no rply 177570", 16'o177570, 1'b1);

        // INIT in the middle of a frame aborts it
        bus_write(XBUF, 16'o000000, 1'b0);
        repeat (30) @(negedge clk);
        check("tx mid frame", 16'(tx), 16'd0);
        init_n = 1'b0;
        @(negedge clk);
        check("init tx idle", 16'(tx), 16'd1);
        check("init ready", 16'(dut.tx_ready), 16'd1);
        init_n = 1'b1;
        @(negedge clk);
        bus_read("XCSR after init", XCSR, 16'o000200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
